approx_adder_error_monitor32: RTL and testbench

Response-side checker for the 32-bit approximate adders. It accepts (add1_i, add2_i, result_i) samples from an approximate adder over a valid/ready handshake and recomputes the exact sum internally. Over a run of N samples it accumulates error metrics: mismatch count, maximum error distance and summed error distance. It sits downstream of the DUT in gate-level and FPGA error-characterisation harnesses, alongside the stimulus drivers.

---
 rtl/approx_adder_error_monitor32.sv | 163 ++++++++++++++++
 tb/tb_approx_adder_error_monitor32.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_error_monitor32.sv
// Error-characterisation monitor for approximate adders: recomputes the
// exact sum and accumulates mismatch count, max and summed error distance.
module approx_adder_error_monitor32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_samples_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [WIDTH:0]   result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [WIDTH:0]   max_ed_o,
  output logic [ACC_W-1:0] sum_ed_o,
  output logic             sat_o
);
  localparam int RW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             s1_vld_q, s1_vld_d;
  logic [RW-1:0]    s1_ed_q, s1_ed_d;
  logic             s1_mis_q, s1_mis_d;
  logic             s2_vld_q, s2_vld_d;
  logic [RW-1:0]    s2_ed_q, s2_ed_d;
  logic             s2_mis_q, s2_mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [RW-1:0]    max_q, max_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sat_q, sat_d;

  logic [RW-1:0]    exact;
  logic [RW-1:0]    ed;
  logic [ACC_W:0]   sum_ext;
  logic             xfer;

  assign exact = {1'b0, add1_i} + {1'b0, add2_i};
  // Larger minus smaller keeps the distance unsigned without wrap.
  assign ed = (exact >= result_i) ? exact - result_i
                                  : result_i - exact;
  assign in_ready_o = (state_q == RUN) && (acc_q < n_q);
  assign xfer = in_valid_i && in_ready_o;
  assign sum_ext = {1'b0, sum_q}
                 + {{(ACC_W + 1 - RW){1'b0}}, s2_ed_q};

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    acc_d    = acc_q;
    s1_vld_d = xfer;
    s1_ed_d  = s1_ed_q;
    s1_mis_d = s1_mis_q;
    s2_vld_d = s1_vld_q;
    s2_ed_d  = s1_ed_q;
    s2_mis_d = s1_mis_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    max_d    = max_q;
    sum_d    = sum_q;
    sat_d    = sat_q;

    if (xfer) begin
      s1_ed_d  = ed;
      s1_mis_d = (ed != '0);
    end

    if (s2_vld_q) begin
      cnt_d = cnt_q + 1'b1;
      err_d = err_q + CNT_W'(s2_mis_q);
      if (s2_ed_q > max_q) max_d = s2_ed_q;
      if (sum_ext[ACC_W]) begin
        sum_d = '1;
        sat_d = 1'b1;
      end else begin
        sum_d = sum_ext[ACC_W-1:0];
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          n_d     = num_samples_i;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          max_d   = '0;
          sum_d   = '0;
          sat_d   = 1'b0;
          state_d = (num_samples_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          acc_d = acc_q + 1'b1;
          if (acc_d == n_q) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!s1_vld_q && !s2_vld_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      n_q      <= '0;
      acc_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_ed_q  <= '0;
      s1_mis_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_ed_q  <= '0;
      s2_mis_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= '0;
      max_q    <= '0;
      sum_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      s1_vld_q <= s1_vld_d;
      s1_ed_q  <= s1_ed_d;
      s1_mis_q <= s1_mis_d;
      s2_vld_q <= s2_vld_d;
      s2_ed_q  <= s2_ed_d;
      s2_mis_q <= s2_mis_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      max_q    <= max_d;
      sum_q    <= sum_d;
      sat_q    <= sat_d;
    end
  end

  assign busy_o       = (state_q == RUN) || (state_q == FLUSH);
  assign done_o       = (state_q == DONE);
  assign sample_cnt_o = cnt_q;
  assign err_cnt_o    = err_q;
  assign max_ed_o     = max_q;
  assign sum_ed_o     = sum_q;
  assign sat_o        = sat_q;
endmodule

// File: tb/tb_approx_adder_error_monitor32.sv
// Randomised bench for approx_adder_error_monitor32 against an
// arithmetic reference model; a 34-bit-accumulator copy covers saturation.
module tb_approx_adder_error_monitor32;
  localparam int W   = 32;
  localparam int CW  = 16;
  localparam int AW  = 48;
  localparam int AWS = 34;
  localparam longint unsigned LIM   = (64'd1 << AW) - 1;
  localparam longint unsigned LIM_S = (64'd1 << AWS) - 1;

  logic clk = 1'b0;
  logic rst_n, start, in_valid;
  logic [CW-1:0] num;
  logic [W-1:0] a, b;
  logic [W:0] r;

  logic rdy, busy, done, sat;
  logic [CW-1:0] scnt, ecnt;
  logic [W:0] maxed;
  logic [AW-1:0] sumed;

  logic rdy_s, busy_s, done_s, sat_s;
  logic [CW-1:0] scnt_s, ecnt_s;
  logic [W:0] maxed_s;
  logic [AWS-1:0] sumed_s;

  always #5 clk = ~clk;

  approx_adder_error_monitor32 u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .num_samples_i(num), .in_valid_i(in_valid),
    .in_ready_o(rdy), .add1_i(a), .add2_i(b),
    .result_i(r), .busy_o(busy), .done_o(done),
    .sample_cnt_o(scnt), .err_cnt_o(ecnt),
    .max_ed_o(maxed), .sum_ed_o(sumed), .sat_o(sat)
  );

  approx_adder_error_monitor32 #(.ACC_W(AWS)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .num_samples_i(num), .in_valid_i(in_valid),
    .in_ready_o(rdy_s), .add1_i(a), .add2_i(b),
    .result_i(r), .busy_o(busy_s), .done_o(done_s),
    .sample_cnt_o(scnt_s), .err_cnt_o(ecnt_s),
    .max_ed_o(maxed_s), .sum_ed_o(sumed_s), .sat_o(sat_s)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  longint unsigned m_cnt, m_err, m_max, m_sum, m_sum_s;
  bit m_sat, m_sat_s;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [32:0] qr[$];

  task automatic m_clear;
    m_cnt = 0; m_err = 0; m_max = 0;
    m_sum = 0; m_sum_s = 0;
    m_sat = 0; m_sat_s = 0;
  endtask

  task automatic model_add(input logic [31:0] x,
                           input logic [31:0] y,
                           input logic [32:0] z);
    longint unsigned ex, rr, e;
    ex = 64'(x) + 64'(y);
    rr = 64'(z);
    e = (ex > rr) ? ex - rr : rr - ex;
    m_cnt++;
    if (e != 0) m_err++;
    if (e > m_max) m_max = e;
    if (m_sum + e > LIM) begin m_sum = LIM; m_sat = 1; end
    else m_sum += e;
    if (m_sum_s + e > LIM_S) begin m_sum_s = LIM_S; m_sat_s = 1; end
    else m_sum_s += e;
  endtask

  task automatic push(input logic [31:0] x,
                      input logic [31:0] y,
                      input logic [32:0] z);
    qa.push_back(x); qb.push_back(y); qr.push_back(z);
  endtask

  task automatic next_sample;
    longint unsigned ex;
    if (qa.size() > 0) begin
      a = qa.pop_front(); b = qb.pop_front(); r = qr.pop_front();
    end else begin
      a = $urandom; b = $urandom;
      ex = 64'(a) + 64'(b);
      case ($urandom_range(0, 3))
        0: r = 33'(ex);
        1: r = 33'(ex + 64'($urandom_range(0, 255)) - 64'd128);
        2: r = {1'($urandom), 32'($urandom)};
        default: r = 33'(ex ^ (64'd1 << $urandom_range(0, 32)));
      endcase
    end
  endtask

  task automatic chk_final;
    chk("cnt", 64'(scnt), m_cnt);
    chk("err", 64'(ecnt), m_err);
    chk("max", 64'(maxed), m_max);
    chk("sum", 64'(sumed), m_sum);
    chk("sat", 64'(sat), 64'(m_sat));
    chk("cnt_s", 64'(scnt_s), m_cnt);
    chk("sum_s", 64'(sumed_s), m_sum_s);
    chk("sat_s", 64'(sat_s), 64'(m_sat_s));
  endtask

  task automatic run(input int n, input int gap, input bit hold);
    int acc = 0, h1 = 0, h2 = 0, cyc = 0;
    bit pend = 0, rdy_now;
    m_clear();
    @(posedge clk); #1;
    start = 1; num = CW'(n);
    @(posedge clk); #1;
    start = 0;
    chk("clr_cnt", 64'(scnt), 0);
    chk("clr_sum", 64'(sumed), 0);
    chk("clr_sat_s", 64'(sat_s), 0);
    if (n == 0) begin
      chk("zero_done", 64'(done), 1);
      chk_final();
      return;
    end
    chk("busy", 64'(busy), 1);
    while (acc < n && cyc < 4000) begin
      if (!pend && $urandom_range(0, 99) >= gap) begin
        next_sample();
        pend = 1;
      end
      in_valid = pend;
      rdy_now = rdy;
      chk("ready", 64'(rdy), 1);
      @(posedge clk); #1;
      cyc++;
      h2 = h1; h1 = acc;
      if (pend && rdy_now) begin
        model_add(a, b, r);
        acc++;
        pend = 0;
      end
      chk("lat_cnt", 64'(scnt), 64'(h2));
    end
    if (acc < n) chk("timeout", 0, 1);
    if (hold) begin next_sample(); in_valid = 1; end
    else in_valid = 0;
    chk("ready_drop", 64'(rdy), 0);
    chk("done_k0", 64'(done), 0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      h2 = h1; h1 = acc;
      if (i < 3) begin
        chk("done_early", 64'(done), 0);
        chk("lat_cnt", 64'(scnt), 64'(h2));
      end
    end
    chk("done", 64'(done), 1);
    chk("busy_off", 64'(busy), 0);
    chk_final();
    repeat (2) @(posedge clk);
    #1;
    chk("stable_cnt", 64'(scnt), m_cnt);
    chk("stable_sum", 64'(sumed), m_sum);
    in_valid = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, 64'(rdy), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_cnt"}, 64'(scnt), 0);
    chk({tag, "_err"}, 64'(ecnt), 0);
    chk({tag, "_max"}, 64'(maxed), 0);
    chk({tag, "_sum"}, 64'(sumed), 0);
    chk({tag, "_sat"}, 64'(sat), 0);
    chk({tag, "_sum_s"}, 64'(sumed_s), 0);
  endtask

  initial begin
    rst_n = 0; start = 0; num = '0;
    in_valid = 1; a = '0; b = '0; r = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1; in_valid = 0;

    push(32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEEC);
    run(1, 0, 0);
    chk("exact_err", 64'(ecnt), 0);

    push(32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEE8);
    push(32'h55555555, 32'hAAAAAAAA, 33'h0FFFF0000);
    push(32'hFFFFFFFF, 32'h00000001, 33'h000000000);
    run(3, 0, 0);
    chk("mixed_max", 64'(maxed), 64'h100000000);

    push(32'h00000001, 32'h00000001, 33'h000000003);
    push(32'h00000010, 32'h00000000, 33'h000000000);
    push(32'h00001000, 32'h00000000, 33'h000000000);
    push(32'h10000000, 32'h00000000, 33'h000000000);
    run(2, 0, 1);
    chk("bp_cnt", 64'(scnt), 2);
    qa.delete(); qb.delete(); qr.delete();

    repeat (4) push(32'hFFFFFFFF, 32'h00000001, 33'h000000000);
    run(4, 0, 0);
    chk("satur_sum_s", 64'(sumed_s), 64'h3FFFFFFFF);

    for (int t = 0; t < 6; t++)
      run($urandom_range(1, 40), $urandom_range(0, 60), 1'($urandom));

    @(posedge clk); #1;
    start = 1; num = CW'(5);
    @(posedge clk); #1;
    start = 0; in_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    chk_zero("mid_rst");
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_done", 64'(done), 0);
      chk("idle_rdy", 64'(rdy), 0);
    end
    in_valid = 0;
    run(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
